tx_serializer: RTL

Downstream stage of the transmit path: consumes the parallel byte stream presented on `d`/`load_en` and shifts each byte out on a single serial line as an asynchronous frame (start, LSB-first data, optional even parity, stop). A one-entry holding register double-buffers the input so the upstream stage can load the next byte while the current frame is still shifting, giving gap-free back-to-back frames.

---
 rtl/tx_serializer_pkg.sv | 20 ++
 rtl/tx_serializer_bit_timer.sv | 33 +++
 rtl/tx_serializer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/tx_serializer_pkg.sv
// tx_ser_pkg: shared types and helpers for the transmit serializer.
//   tx_state_e  - frame FSM states (IDLE, START, DATA, PARITY, STOP)
//   frame_len() - clk cycles occupied by one complete frame on the line
package tx_ser_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // start + data + optional parity + stop, each one bit time long
    function automatic int frame_len(input int data_w, input int clks_per_bit,
                                     input int parity_en);
        return (2 + data_w + parity_en) * clks_per_bit;
    endfunction

endpackage

// File: rtl/tx_serializer_bit_timer.sv
// tx_bit_timer: counts clk cycles within one serial bit time.
//   clk, reset_n - clock, async active-low reset
//   restart      - hold the counter at 0 (used while the line is idle)
//   bit_end      - high in the last cycle of each bit time
module tx_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_end = (cnt_q == LAST);

    // Wraps to 0 at the end of each bit, so consecutive bits (and
    // back-to-back frames) need no explicit restart.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || bit_end) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/tx_serializer.sv
// tx_serializer: shifts parallel bytes out as asynchronous serial frames
// (start 0, LSB-first data, optional even parity, stop 1). A one-entry
// holding register lets the next byte be loaded while a frame is shifting,
// giving gap-free back-to-back frames.
//   clk, reset_n - clock, async active-low reset
//   load_en, d   - byte-valid strobe and byte, accepted when ready=1
//   ready        - holding register empty
//   busy         - frame on the line
//   txd          - registered serial output, idle high
//   done         - one-cycle pulse in the last cycle of each stop bit
//   overrun      - one-cycle pulse after a load_en seen with ready=0
module tx_serializer
    import tx_ser_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_en,
    input  logic [DATA_W-1:0] d,
    output logic              ready,
    output logic              busy,
    output logic              txd,
    output logic              done,
    output logic              overrun
);

    localparam int BCNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_W - 1);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              par_q, par_d;
    logic              txd_q, txd_d;
    logic              ovr_q, ovr_d;
    logic              done_c;
    logic              accept;
    logic              bit_end;

    // Timer is held at 0 while idle so a new frame's start bit is full length.
    tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .restart(state_q == IDLE),
        .bit_end(bit_end)
    );

    assign accept = load_en && !hold_full_q;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bcnt_d      = bcnt_q;
        par_d       = par_q;
        done_c      = 1'b0;
        ovr_d       = load_en && hold_full_q;
        txd_d       = 1'b1;

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    state_d     = START;
                    shreg_d     = hold_q;
                    hold_full_d = 1'b0;
                end else if (accept) begin
                    state_d = START;
                    shreg_d = d;
                end
                bcnt_d = '0;
                par_d  = 1'b0;
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    // Parity accumulates the bits as they leave the line.
                    par_d   = par_q ^ shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    if (bcnt_q == BCNT_LAST) begin
                        bcnt_d  = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bcnt_d = bcnt_q + BCNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    done_c = 1'b1;
                    if (hold_full_q) begin
                        // Drain straight into the next start bit, no idle gap.
                        state_d     = START;
                        shreg_d     = hold_q;
                        hold_full_d = 1'b0;
                        par_d       = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Bytes arriving mid-frame park in the holding register. A byte on
        // the drain edge sees hold_full_q=1 and is dropped as an overrun.
        if (accept && state_q != IDLE) begin
            hold_d      = d;
            hold_full_d = 1'b1;
        end

        // txd is registered: derive it from the state being entered.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg_d[0];
            PARITY:  txd_d = par_d;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bcnt_q      <= '0;
            par_q       <= 1'b0;
            txd_q       <= 1'b1;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bcnt_q      <= bcnt_d;
            par_q       <= par_d;
            txd_q       <= txd_d;
            ovr_q       <= ovr_d;
        end
    end

    assign ready   = !hold_full_q;
    assign busy    = (state_q != IDLE);
    assign txd     = txd_q;
    assign done    = done_c;
    assign overrun = ovr_q;

endmodule
